janus_cube_mmio_regs: RTL and testbench

- MMIO responder and register front-end for the Janus cube accelerator; the target side of the host memory-mapped write/read interface.
- Decodes host writes into:
  - control pulses (START / soft RESET);
  - a MATMUL instruction queue;
  - L0A/L0B tile-buffer element writes with per-entry valid tracking.
- Answers host reads with status and valid bitmaps.
- Sits between the host bus and the cube decoder / systolic core.

---
 rtl/janus_cube_mmio_regs.sv | 208 ++++++++++++++++++++
 tb/tb_janus_cube_mmio_regs.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/janus_cube_mmio_regs.sv
// MMIO register front-end for the Janus cube: decodes host writes into control pulses,
// a MATMUL instruction queue and L0A/L0B element writes; answers status/bitmap reads.
module janus_cube_mmio_regs #(
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
   parameter int          ENTRIES    = 64,
   parameter int          ARRAY_SIZE = 16,
   parameter int          QDEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_wvalid,
   input  logic [63:0]                 mem_waddr,
   input  logic [63:0]                 mem_wdata,
   input  logic [63:0]                 mem_raddr,
   output logic [63:0]                 mem_rdata,
   output logic                        start_pulse,
   output logic                        soft_reset_pulse,
   output logic                        inst_valid,
   input  logic                        inst_ready,
   output logic [15:0]                 inst_m,
   output logic [15:0]                 inst_k,
   output logic [15:0]                 inst_n,
   output logic                        l0a_we,
   output logic                        l0b_we,
   output logic [$clog2(ENTRIES)-1:0]  l0_entry,
   output logic [3:0]                  l0_row,
   output logic [3:0]                  l0_col,
   output logic [15:0]                 l0_wdata,
   output logic [ENTRIES-1:0]          l0a_valid,
   output logic [ENTRIES-1:0]          l0b_valid,
   input  logic                        core_busy,
   input  logic                        core_done,
   output logic                        queue_full,
   output logic                        queue_empty
);

   localparam int EW = $clog2(ENTRIES);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
   localparam logic [3:0]    LAST_RC  = 4'(ARRAY_SIZE - 1);

   logic [63:0]   w_off;
   logic          w_in_win;
   logic          w_ctrl;
   logic          w_soft;
   logic          w_start;
   logic          w_push;
   logic          w_l0a;
   logic          w_l0b;
   logic [15:0]   w_rel;
   logic [EW-1:0] w_entry;
   logic          w_last;
   logic          w_pop;
   logic          w_full;
   logic          w_accept;
   logic          w_drop;
   logic [47:0]   w_head;
   logic [63:0]   w_roff;
   logic [63:0]   w_status;
   logic [63:0]   w_rdata;
   logic          w_unused;

   logic          r_start;
   logic          r_soft;
   logic          r_l0a_we;
   logic          r_l0b_we;
   logic [EW-1:0] r_entry;
   logic [3:0]    r_row;
   logic [3:0]    r_col;
   logic [15:0]   r_l0_wdata;
   logic [ENTRIES-1:0] r_l0a_valid;
   logic [ENTRIES-1:0] r_l0b_valid;
   logic          r_push_p1;
   logic [47:0]   r_push_data_p1;
   logic [47:0]   r_fifo [QDEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic          r_done;
   logic [63:0]   r_rdata;

   // Write decode: element offsets are relative to the start of each tile buffer.
   assign w_off    = mem_waddr - BASE_ADDR;
   assign w_in_win = mem_wvalid && (mem_waddr >= BASE_ADDR) && (w_off < 64'h9000);
   assign w_ctrl   = w_in_win && (w_off == 64'h0);
   assign w_soft   = w_ctrl && mem_wdata[1];
   assign w_start  = w_ctrl && !mem_wdata[1] && mem_wdata[0];
   assign w_push   = w_in_win && (w_off == 64'h10);
   assign w_l0a    = w_in_win && (w_off >= 64'h1000) && (w_off < 64'h5000);
   assign w_l0b    = w_in_win && (w_off >= 64'h5000);
   assign w_rel    = w_off[15:0] - (w_l0b ? 16'h5000 : 16'h1000);
   assign w_entry  = w_rel[8 +: EW];
   assign w_last   = (w_rel[7:4] == LAST_RC) && (w_rel[3:0] == LAST_RC);
   assign w_unused = &{1'b0, mem_wdata[63:48], w_rel[15:14]};

   assign w_full   = (r_count == FULL_CNT);
   assign w_pop    = inst_valid && inst_ready;
   assign w_accept = r_push_p1 && !w_full;
   assign w_drop   = r_push_p1 && w_full;
   assign w_head   = r_fifo[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_start        <= 1'b0;
         r_soft         <= 1'b0;
         r_l0a_we       <= 1'b0;
         r_l0b_we       <= 1'b0;
         r_entry        <= '0;
         r_row          <= '0;
         r_col          <= '0;
         r_l0_wdata     <= '0;
         r_l0a_valid    <= '0;
         r_l0b_valid    <= '0;
         r_push_p1      <= 1'b0;
         r_push_data_p1 <= '0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_overflow     <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_start   <= w_start;
         r_soft    <= w_soft;
         r_l0a_we  <= w_l0a;
         r_l0b_we  <= w_l0b;
         r_push_p1 <= w_push;
         if (w_push) r_push_data_p1 <= mem_wdata[47:0];
         if (w_l0a || w_l0b) begin
            r_entry    <= w_entry;
            r_row      <= w_rel[7:4];
            r_col      <= w_rel[3:0];
            r_l0_wdata <= mem_wdata[15:0];
         end
         // Soft reset wipes queue and tracking state on the same edge its pulse rises.
         if (w_soft) begin
            r_l0a_valid <= '0;
            r_l0b_valid <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
         end else begin
            if (w_l0a && w_last) r_l0a_valid[w_entry] <= 1'b1;
            if (w_l0b && w_last) r_l0b_valid[w_entry] <= 1'b1;
            if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_accept && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_accept && w_pop) r_count <= r_count - CW'(1);
            if (w_drop) r_overflow <= 1'b1;
            if (core_done)    r_done <= 1'b1;
            else if (w_start) r_done <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_fifo[r_wr_ptr] <= r_push_data_p1;
   end

   // Read path: one registered stage, no side effects.
   assign w_roff = mem_raddr - BASE_ADDR;

   always_comb begin
      w_status             = '0;
      w_status[0]          = r_done;
      w_status[1]          = core_busy;
      w_status[2]          = w_full;
      w_status[3]          = (r_count == '0);
      w_status[4]          = r_overflow;
      w_status[8 +: CW]    = r_count;
      w_rdata              = '0;
      if (mem_raddr >= BASE_ADDR) begin
         case (w_roff)
            64'h08:  w_rdata = w_status;
            64'h18:  w_rdata = 64'(r_l0a_valid);
            64'h20:  w_rdata = 64'(r_l0b_valid);
            default: w_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_rdata <= '0;
      else      r_rdata <= w_rdata;
   end

   assign mem_rdata        = r_rdata;
   assign start_pulse      = r_start;
   assign soft_reset_pulse = r_soft;
   assign l0a_we           = r_l0a_we;
   assign l0b_we           = r_l0b_we;
   assign l0_entry         = r_entry;
   assign l0_row           = r_row;
   assign l0_col           = r_col;
   assign l0_wdata         = r_l0_wdata;
   assign l0a_valid        = r_l0a_valid;
   assign l0b_valid        = r_l0b_valid;
   assign inst_valid       = (r_count != '0);
   assign inst_m           = inst_valid ? w_head[15:0]  : 16'h0;
   assign inst_k           = inst_valid ? w_head[31:16] : 16'h0;
   assign inst_n           = inst_valid ? w_head[47:32] : 16'h0;
   assign queue_full       = w_full;
   assign queue_empty      = (r_count == '0);

endmodule

// File: tb/tb_janus_cube_mmio_regs.sv
// Scoreboard bench for janus_cube_mmio_regs: stimulus queues expected responses,
// a negedge monitor pops and compares whenever the DUT presents an event.
module tb_janus_cube_mmio_regs;

   localparam logic [63:0] BASE = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_wvalid;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_raddr;
   logic [63:0] mem_rdata;
   logic        start_pulse;
   logic        soft_reset_pulse;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst_m;
   logic [15:0] inst_k;
   logic [15:0] inst_n;
   logic        l0a_we;
   logic        l0b_we;
   logic [5:0]  l0_entry;
   logic [3:0]  l0_row;
   logic [3:0]  l0_col;
   logic [15:0] l0_wdata;
   logic [63:0] l0a_valid;
   logic [63:0] l0b_valid;
   logic        core_busy;
   logic        core_done;
   logic        queue_full;
   logic        queue_empty;

   always #5 clk = ~clk;

   janus_cube_mmio_regs dut (
      .clk(clk), .rst(rst),
      .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .start_pulse(start_pulse), .soft_reset_pulse(soft_reset_pulse),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_m(inst_m), .inst_k(inst_k), .inst_n(inst_n),
      .l0a_we(l0a_we), .l0b_we(l0b_we), .l0_entry(l0_entry),
      .l0_row(l0_row), .l0_col(l0_col), .l0_wdata(l0_wdata),
      .l0a_valid(l0a_valid), .l0b_valid(l0b_valid),
      .core_busy(core_busy), .core_done(core_done),
      .queue_full(queue_full), .queue_empty(queue_empty)
   );

   typedef struct packed {
      logic        a;
      logic        b;
      logic [5:0]  e;
      logic [3:0]  r;
      logic [3:0]  c;
      logic [15:0] d;
      logic [63:0] va;
      logic [63:0] vb;
   } l0_t;

   l0_t         q_l0[$];
   logic [1:0]  q_ctrl[$];
   logic [47:0] q_inst[$];
   logic [63:0] q_rd[$];

   int   total = 0;
   int   bad   = 0;
   logic rd_issue = 1'b0;
   logic rd_seen  = 1'b0;
   l0_t  ex_l0;
   logic [1:0]  ex_ctrl;
   logic [47:0] ex_inst;
   logic [63:0] ex_rd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic l0_t mk_l0(input logic a, input logic b, input int e, input int r,
                                 input int c, input logic [15:0] d,
                                 input logic [63:0] va, input logic [63:0] vb);
      l0_t t;
      t.a = a; t.b = b; t.e = 6'(e); t.r = 4'(r); t.c = 4'(c);
      t.d = d; t.va = va; t.vb = vb;
      return t;
   endfunction

   function automatic logic [47:0] mk_inst(input int base);
      return {16'(base + 32), 16'(base + 16), 16'(base)};
   endfunction

   always @(posedge clk) rd_seen <= rd_issue;

   // Monitor: every DUT event must match the head of its queue.
   always @(negedge clk) begin
      if (l0a_we || l0b_we) begin
         if (q_l0.size() == 0) chk("l0_unexpected", {62'h0, l0a_we, l0b_we}, 64'h0);
         else begin
            ex_l0 = q_l0.pop_front();
            chk("l0_we", {62'h0, l0a_we, l0b_we}, {62'h0, ex_l0.a, ex_l0.b});
            chk("l0_loc", {34'h0, l0_entry, l0_row, l0_col, l0_wdata},
                {34'h0, ex_l0.e, ex_l0.r, ex_l0.c, ex_l0.d});
            chk("l0a_valid", l0a_valid, ex_l0.va);
            chk("l0b_valid", l0b_valid, ex_l0.vb);
         end
      end
      if (start_pulse || soft_reset_pulse) begin
         if (q_ctrl.size() == 0) chk("ctrl_unexpected", {62'h0, start_pulse, soft_reset_pulse}, 64'h0);
         else begin
            ex_ctrl = q_ctrl.pop_front();
            chk("ctrl_pulse", {62'h0, start_pulse, soft_reset_pulse}, {62'h0, ex_ctrl});
         end
      end
      if (inst_valid && inst_ready) begin
         if (q_inst.size() == 0) chk("inst_unexpected", {16'h0, inst_n, inst_k, inst_m}, 64'h0);
         else begin
            ex_inst = q_inst.pop_front();
            chk("inst_head", {16'h0, inst_n, inst_k, inst_m}, {16'h0, ex_inst});
         end
      end
      if (rd_seen && q_rd.size() != 0) begin
         ex_rd = q_rd.pop_front();
         chk("rdata", mem_rdata, ex_rd);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [63:0] a, input logic [63:0] d);
      mem_wvalid = 1'b1;
      mem_waddr  = a;
      mem_wdata  = d;
      @(posedge clk);
      #1;
      mem_wvalid = 1'b0;
      mem_waddr  = '0;
      mem_wdata  = '0;
   endtask

   task automatic rd(input logic [63:0] a, input logic [63:0] exp);
      q_rd.push_back(exp);
      mem_raddr = a;
      rd_issue  = 1'b1;
      @(posedge clk);
      #1;
      rd_issue  = 1'b0;
      mem_raddr = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; mem_wvalid = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_raddr = '0;
      inst_ready = 1'b0; core_busy = 1'b0; core_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pulses", {58'h0, start_pulse, soft_reset_pulse, inst_valid, l0a_we, l0b_we, queue_full}, 64'h0);
      chk("rst_empty", {63'h0, queue_empty}, 64'h1);
      chk("rst_rdata", mem_rdata, 64'h0);
      chk("rst_bitmaps", l0a_valid | l0b_valid, 64'h0);
      chk("rst_fields", {6'h0, l0_entry, l0_row, l0_col, l0_wdata, inst_m, inst_k}, 64'h0);
      rst = 1'b1;
      idle(2);
      rd(BASE + 64'h8, 64'h8);

      // Tile-buffer element writes
      q_l0.push_back(mk_l0(1, 0, 0, 15, 15, 16'h0001, 64'h1, 64'h0));
      wr(BASE + 64'h10FF, 64'h1);
      q_l0.push_back(mk_l0(0, 1, 1, 0, 0, 16'hBEEF, 64'h1, 64'h0));
      wr(BASE + 64'h5100, 64'hBEEF);
      q_l0.push_back(mk_l0(0, 1, 63, 15, 15, 16'h1234, 64'h1, 64'h8000_0000_0000_0000));
      wr(BASE + 64'h8FFF, 64'hFFFF_0000_0000_1234);
      q_l0.push_back(mk_l0(1, 0, 2, 15, 14, 16'h0055, 64'h1, 64'h8000_0000_0000_0000));
      wr(BASE + 64'h12FE, 64'h55);
      idle(1);
      rd(BASE + 64'h18, 64'h1);
      rd(BASE + 64'h20, 64'h8000_0000_0000_0000);

      // Fill queue past depth, then drain in order
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) q_inst.push_back(mk_inst(i));
         wr(BASE + 64'h10, {16'h0, mk_inst(i)});
      end
      idle(2);
      chk("full_after_4", {63'h0, queue_full}, 64'h1);
      rd(BASE + 64'h8, 64'h414);
      inst_ready = 1'b1;
      idle(6);
      inst_ready = 1'b0;
      chk("empty_after_drain", {63'h0, queue_empty}, 64'h1);
      rd(BASE + 64'h8, 64'h18);

      // Push into empty queue: visible two cycles after the write strobe
      wr(BASE + 64'h10, 64'h0000_0020_0020_0020);
      chk("inst_valid_w1", {63'h0, inst_valid}, 64'h0);
      idle(1);
      chk("inst_valid_w2", {63'h0, inst_valid}, 64'h1);
      chk("inst_fields", {16'h0, inst_n, inst_k, inst_m}, 64'h0000_0020_0020_0020);
      idle(2);
      chk("inst_hold", {15'h0, inst_valid, inst_n, inst_k, inst_m}, 64'h0001_0020_0020_0020);
      q_inst.push_back(48'h0020_0020_0020);
      inst_ready = 1'b1;
      idle(1);
      inst_ready = 1'b0;
      chk("empty_after_pop", {63'h0, queue_empty}, 64'h1);

      // START, done latch, busy reflection
      q_ctrl.push_back(2'b10);
      wr(BASE, 64'h1);
      core_done = 1'b1;
      idle(1);
      core_done = 1'b0;
      idle(1);
      rd(BASE + 64'h8, 64'h19);
      core_busy = 1'b1;
      rd(BASE + 64'h8, 64'h1B);
      core_busy = 1'b0;
      q_ctrl.push_back(2'b10);
      wr(BASE, 64'h1);
      idle(1);
      rd(BASE + 64'h8, 64'h18);
      core_done = 1'b1;
      idle(1);
      core_done = 1'b0;
      wr(BASE + 64'h10, 64'h0000_0001_0001_0001);
      idle(2);
      chk("inst_before_soft", {63'h0, inst_valid}, 64'h1);

      // Soft reset wins over START and clears all tracked state
      q_ctrl.push_back(2'b01);
      wr(BASE, 64'h3);
      chk("inst_drop_soft", {62'h0, inst_valid, queue_empty}, 64'h1);
      idle(1);
      rd(BASE + 64'h8, 64'h8);
      rd(BASE + 64'h18, 64'h0);
      rd(BASE + 64'h20, 64'h0);

      // Writes outside the decoded map
      wr(64'h7FFF_FFF8, 64'h3);
      wr(BASE + 64'h9000, 64'h3);
      wr(BASE + 64'h8, 64'hFFFF);
      wr(BASE + 64'h0FFF, 64'h1);
      idle(2);
      rd(BASE + 64'h8, 64'h8);
      rd(BASE + 64'h10, 64'h0);

      // Hard reset in the middle of a drain
      q_l0.push_back(mk_l0(1, 0, 5, 15, 15, 16'h0007, 64'h20, 64'h0));
      wr(BASE + 64'h15FF, 64'h7);
      for (int i = 1; i <= 5; i++) wr(BASE + 64'h10, {16'h0, mk_inst(i + 64)});
      idle(2);
      rd(BASE + 64'h8, 64'h414);
      q_inst.push_back(mk_inst(65));
      q_inst.push_back(mk_inst(66));
      inst_ready = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(1);
      inst_ready = 1'b0;
      chk("rst_mid_queue", {62'h0, inst_valid, queue_empty}, 64'h1);
      chk("rst_mid_bitmap", l0a_valid, 64'h0);
      chk("rst_mid_rdata", mem_rdata, 64'h0);
      rst = 1'b1;
      idle(1);
      rd(BASE + 64'h8, 64'h8);
      idle(3);

      chk("q_l0_left", 64'(q_l0.size()), 64'h0);
      chk("q_ctrl_left", 64'(q_ctrl.size()), 64'h0);
      chk("q_inst_left", 64'(q_inst.size()), 64'h0);
      chk("q_rd_left", 64'(q_rd.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
